sseg_anim_engine: RTL and testbench



---
 rtl/sseg_anim_engine.sv | 145 ++++++++++++++
 tb/tb_sseg_anim_engine.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_anim_engine.sv
// Seven-segment animation engine for an N-digit common-anode display.
// Heartbeat, rotating square, hex pass-through and blank, with pause, reverse
// and a step strobe. Digit scanning is built in and both an and sseg are registered.
module sseg_anim_engine #(
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned TICK_DIV = 694_444,
    parameter int unsigned SCAN_DIV = 50_000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    en,
    input  logic                    dir,
    input  logic [1:0]              mode,
    input  logic [4*N_DIGITS-1:0]   hex_in,
    output logic [N_DIGITS-1:0]     an,
    output logic [7:0]              sseg,
    output logic [7:0]              phase,
    output logic                    step
);

    localparam int unsigned H      = N_DIGITS / 2;
    localparam int unsigned IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned TICK_W = $clog2(TICK_DIV);
    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [TICK_W-1:0] tick;
    logic [SCAN_W-1:0] scan_cnt;
    logic [IDX_W-1:0]  scan_idx;
    logic [1:0]        mode_q;

    logic [7:0]        frames_c;
    logic [7:0]        phase_next_c;
    logic [7:0]        pattern_c;
    int unsigned       pat_i;
    int unsigned       pat_p;

    // Active-low segment decode of one hex nibble, dp off.
    function automatic logic [7:0] hex_to_sseg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

    // Number of animation frames in the currently registered mode.
    always_comb begin
        case (mode_q)
            2'd0:    frames_c = 8'(H);
            2'd1:    frames_c = 8'(2 * N_DIGITS);
            default: frames_c = 8'd1;
        endcase
    end

    // Next phase for a step, wrapping in either direction.
    always_comb begin
        phase_next_c = phase;
        if (!dir) begin
            phase_next_c = (phase == frames_c - 8'd1) ? 8'd0 : phase + 8'd1;
        end else begin
            phase_next_c = (phase == 8'd0) ? frames_c - 8'd1 : phase - 8'd1;
        end
    end

    // Segment pattern for the digit currently being scanned.
    always_comb begin
        pattern_c = 8'hFF;
        pat_i     = 32'(scan_idx);
        pat_p     = 32'(phase);
        case (mode_q)
            2'd0: begin
                if (pat_i == H + pat_p) begin
                    pattern_c = 8'hF9;
                end else if ((pat_p < H) && (pat_i == H - 1 - pat_p)) begin
                    pattern_c = 8'hCF;
                end
            end
            2'd1: begin
                if (pat_p < N_DIGITS) begin
                    if (pat_i == N_DIGITS - 1 - pat_p) pattern_c = 8'h9C;
                end else if (pat_i == pat_p - N_DIGITS) begin
                    pattern_c = 8'hA3;
                end
            end
            2'd2:    pattern_c = hex_to_sseg(hex_in[4*pat_i +: 4]);
            default: pattern_c = 8'hFF;
        endcase
    end

    // Tick/phase sequencing, digit scan and registered display outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tick     <= '0;
            phase    <= 8'd0;
            scan_idx <= '0;
            scan_cnt <= '0;
            mode_q   <= mode;
            an       <= '1;
            sseg     <= 8'hFF;
            step     <= 1'b0;
        end else begin
            an     <= ~(N_DIGITS'(1) << scan_idx);
            sseg   <= pattern_c;
            mode_q <= mode;
            step   <= 1'b0;

            if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                scan_idx <= (scan_idx == IDX_W'(N_DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end

            // A mode change restarts the animation and suppresses any coincident step.
            if (mode != mode_q) begin
                phase <= 8'd0;
                tick  <= '0;
            end else if (en) begin
                if (tick == TICK_W'(TICK_DIV - 1)) begin
                    tick  <= '0;
                    phase <= phase_next_c;
                    step  <= 1'b1;
                end else begin
                    tick <= tick + TICK_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sseg_anim_engine.sv
// Directed testbench for sseg_anim_engine (N_DIGITS=4, TICK_DIV=4, SCAN_DIV=2).
module tb_sseg_anim_engine;

    localparam int N  = 4;
    localparam int TD = 4;
    localparam int SD = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en;
    logic        dir;
    logic [1:0]  mode;
    logic [15:0] hex_in;
    logic [3:0]  an;
    logic [7:0]  sseg;
    logic [7:0]  phase;
    logic        step;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int edge_cnt  = 0;
    logic [7:0] frame [N];
    logic [7:0] exp_fr [N];

    sseg_anim_engine #(.N_DIGITS(N), .TICK_DIV(TD), .SCAN_DIV(SD)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .dir(dir), .mode(mode),
        .hex_in(hex_in), .an(an), .sseg(sseg), .phase(phase), .step(step)
    );

    always #5 clk = ~clk;

    // Edges since reset release, used to predict the scan sequence.
    always @(posedge clk) begin
        if (!reset_n) edge_cnt <= 0;
        else          edge_cnt <= edge_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        cyc();
        cyc();
        reset_n = 1'b1;
    endtask

    // One settling edge, then record sseg per digit over two full scan rounds.
    task automatic capture_frame;
        logic [3:0] seen;
        logic [3:0] oh;
        bit bad;
        bit found;
        cyc();
        seen = 4'b0;
        bad  = 1'b0;
        for (int c = 0; c < 2 * N * SD; c++) begin
            cyc();
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                oh = 4'b1 << k;
                if (an === ~oh) begin
                    frame[k] = sseg;
                    seen[k]  = 1'b1;
                    found    = 1'b1;
                end
            end
            if (!found) bad = 1'b1;
        end
        total_cnt++;
        if (bad || seen !== 4'hF)
            $display("FAIL capture_an: an=%h seen=%b, required one-hot-low covering all digits", an, seen);
        else pass_cnt++;
    endtask

    // Run n full tick periods with en=1, counting step pulses; leaves en=0.
    task automatic advance(input int n, output int steps);
        steps = 0;
        en = 1'b1;
        for (int i = 0; i < n * TD; i++) begin
            cyc();
            if (step === 1'b1) steps++;
        end
        en = 1'b0;
    endtask

    task automatic test_reset;
        mode = 2'd0; en = 1'b0; dir = 1'b0; hex_in = 16'h0;
        reset_n = 1'b0;
        repeat (5) cyc();
        total_cnt++; if (an !== 4'hF)    $display("FAIL reset_an: got %h, required F", an);       else pass_cnt++;
        total_cnt++; if (sseg !== 8'hFF) $display("FAIL reset_sseg: got %h, required FF", sseg);  else pass_cnt++;
        total_cnt++; if (phase !== 8'd0) $display("FAIL reset_phase: got %0d, required 0", phase); else pass_cnt++;
        total_cnt++; if (step !== 1'b0)  $display("FAIL reset_step: got %b, required 0", step);   else pass_cnt++;
        reset_n = 1'b1;
        cyc();
        total_cnt++; if (an !== 4'hE)    $display("FAIL first_an: got %h, required E", an);       else pass_cnt++;
        total_cnt++; if (sseg !== 8'hFF) $display("FAIL first_sseg: got %h, required FF", sseg);  else pass_cnt++;
    endtask

    task automatic test_heartbeat;
        bit early;
        int s;
        mode = 2'd0; en = 1'b0; dir = 1'b0;
        do_reset();
        capture_frame();
        exp_fr[0] = 8'hFF; exp_fr[1] = 8'hCF; exp_fr[2] = 8'hF9; exp_fr[3] = 8'hFF;
        for (int k = 0; k < N; k++) begin
            total_cnt++;
            if (frame[k] !== exp_fr[k]) $display("FAIL hb_p0_digit%0d: got %h, required %h", k, frame[k], exp_fr[k]);
            else pass_cnt++;
        end
        en = 1'b1;
        early = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (step !== 1'b0) early = 1'b1;
        end
        cyc();
        en = 1'b0;
        total_cnt++; if (early)          $display("FAIL hb_early_step: got early pulse, required none"); else pass_cnt++;
        total_cnt++; if (step !== 1'b1)  $display("FAIL hb_step: got %b, required 1", step);           else pass_cnt++;
        total_cnt++; if (phase !== 8'd1) $display("FAIL hb_phase1: got %0d, required 1", phase);       else pass_cnt++;
        cyc();
        total_cnt++; if (step !== 1'b0)  $display("FAIL hb_step_width: got %b, required 0", step);     else pass_cnt++;
        capture_frame();
        exp_fr[0] = 8'hCF; exp_fr[1] = 8'hFF; exp_fr[2] = 8'hFF; exp_fr[3] = 8'hF9;
        for (int k = 0; k < N; k++) begin
            total_cnt++;
            if (frame[k] !== exp_fr[k]) $display("FAIL hb_p1_digit%0d: got %h, required %h", k, frame[k], exp_fr[k]);
            else pass_cnt++;
        end
        advance(1, s);
        total_cnt++; if (s != 1)         $display("FAIL hb_wrap_steps: got %0d, required 1", s);      else pass_cnt++;
        total_cnt++; if (phase !== 8'd0) $display("FAIL hb_wrap_phase: got %0d, required 0", phase);  else pass_cnt++;
    endtask

    task automatic test_square;
        int s;
        mode = 2'd1; en = 1'b0; dir = 1'b0;
        do_reset();
        capture_frame();
        exp_fr[0] = 8'hFF; exp_fr[1] = 8'hFF; exp_fr[2] = 8'hFF; exp_fr[3] = 8'h9C;
        for (int k = 0; k < N; k++) begin
            total_cnt++;
            if (frame[k] !== exp_fr[k]) $display("FAIL sq_p0_digit%0d: got %h, required %h", k, frame[k], exp_fr[k]);
            else pass_cnt++;
        end
        advance(4, s);
        total_cnt++; if (s != 4)         $display("FAIL sq_steps4: got %0d, required 4", s);      else pass_cnt++;
        total_cnt++; if (phase !== 8'd4) $display("FAIL sq_phase4: got %0d, required 4", phase); else pass_cnt++;
        capture_frame();
        exp_fr[0] = 8'hA3; exp_fr[1] = 8'hFF; exp_fr[2] = 8'hFF; exp_fr[3] = 8'hFF;
        for (int k = 0; k < N; k++) begin
            total_cnt++;
            if (frame[k] !== exp_fr[k]) $display("FAIL sq_p4_digit%0d: got %h, required %h", k, frame[k], exp_fr[k]);
            else pass_cnt++;
        end
        advance(3, s);
        total_cnt++; if (phase !== 8'd7) $display("FAIL sq_phase7: got %0d, required 7", phase);     else pass_cnt++;
        advance(1, s);
        total_cnt++; if (phase !== 8'd0) $display("FAIL sq_wrap: got %0d, required 0", phase);       else pass_cnt++;
        dir = 1'b1;
        advance(1, s);
        total_cnt++; if (phase !== 8'd7) $display("FAIL sq_rev_wrap: got %0d, required 7", phase);   else pass_cnt++;
        capture_frame();
        total_cnt++; if (frame[3] !== 8'hA3) $display("FAIL sq_p7_digit3: got %h, required A3", frame[3]); else pass_cnt++;
        total_cnt++; if (frame[0] !== 8'hFF) $display("FAIL sq_p7_digit0: got %h, required FF", frame[0]); else pass_cnt++;
        dir = 1'b0;
    endtask

    task automatic test_pause;
        bit frozen_bad;
        bit an_bad;
        logic [3:0] exp_an;
        logic [3:0] oh;
        mode = 2'd0; en = 1'b0; dir = 1'b0;
        do_reset();
        en = 1'b1;
        cyc();
        cyc();
        en = 1'b0;
        frozen_bad = 1'b0;
        an_bad     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (phase !== 8'd0 || step !== 1'b0) frozen_bad = 1'b1;
            oh     = 4'b1 << (((edge_cnt - 1) / 2) % 4);
            exp_an = ~oh;
            if (an !== exp_an) an_bad = 1'b1;
        end
        total_cnt++; if (frozen_bad) $display("FAIL pause_frozen: phase=%0d step=%b, required 0/0", phase, step); else pass_cnt++;
        total_cnt++; if (an_bad)     $display("FAIL pause_scan: an=%h, required E,D,B,7 every 2 cycles", an); else pass_cnt++;
        en = 1'b1;
        cyc();
        total_cnt++; if (step !== 1'b0) $display("FAIL pause_resume_early: got %b, required 0", step); else pass_cnt++;
        cyc();
        en = 1'b0;
        total_cnt++; if (step !== 1'b1 || phase !== 8'd1)
            $display("FAIL pause_resume_step: step=%b phase=%0d, required 1/1", step, phase);
        else pass_cnt++;
    endtask

    task automatic test_mode_change;
        bit early;
        mode = 2'd0; en = 1'b0; dir = 1'b0;
        do_reset();
        en = 1'b1;
        repeat (4) cyc();
        repeat (2) cyc();
        mode = 2'd1;
        cyc();
        total_cnt++; if (step !== 1'b0 || phase !== 8'd0)
            $display("FAIL mc_mid: step=%b phase=%0d, required 0/0", step, phase);
        else pass_cnt++;
        early = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (step !== 1'b0) early = 1'b1;
        end
        cyc();
        total_cnt++; if (early || step !== 1'b1 || phase !== 8'd1)
            $display("FAIL mc_mid_next: early=%b step=%b phase=%0d, required 0/1/1", early, step, phase);
        else pass_cnt++;
        repeat (3) cyc();
        mode = 2'd0;
        cyc();
        total_cnt++; if (step !== 1'b0 || phase !== 8'd0)
            $display("FAIL mc_terminal: step=%b phase=%0d, required 0/0", step, phase);
        else pass_cnt++;
        early = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (step !== 1'b0) early = 1'b1;
        end
        cyc();
        en = 1'b0;
        total_cnt++; if (early || step !== 1'b1 || phase !== 8'd1)
            $display("FAIL mc_terminal_next: early=%b step=%b phase=%0d, required 0/1/1", early, step, phase);
        else pass_cnt++;
    endtask

    task automatic test_hex;
        int s;
        mode = 2'd2; en = 1'b0; dir = 1'b0; hex_in = 16'h12AF;
        do_reset();
        capture_frame();
        exp_fr[0] = 8'h8E; exp_fr[1] = 8'h88; exp_fr[2] = 8'hA4; exp_fr[3] = 8'hF9;
        for (int k = 0; k < N; k++) begin
            total_cnt++;
            if (frame[k] !== exp_fr[k]) $display("FAIL hex_digit%0d: got %h, required %h", k, frame[k], exp_fr[k]);
            else pass_cnt++;
        end
        advance(1, s);
        total_cnt++; if (s != 1 || phase !== 8'd0)
            $display("FAIL hex_single_frame: steps=%0d phase=%0d, required 1/0", s, phase);
        else pass_cnt++;
        mode = 2'd3;
        capture_frame();
        for (int k = 0; k < N; k++) begin
            total_cnt++;
            if (frame[k] !== 8'hFF) $display("FAIL blank_digit%0d: got %h, required FF", k, frame[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid;
        mode = 2'd0; en = 1'b0; dir = 1'b0;
        do_reset();
        en = 1'b1;
        repeat (3) cyc();
        reset_n = 1'b0;
        cyc();
        total_cnt++; if (step !== 1'b0 || phase !== 8'd0 || an !== 4'hF || sseg !== 8'hFF)
            $display("FAIL reset_mid: step=%b phase=%0d an=%h sseg=%h, required 0/0/F/FF", step, phase, an, sseg);
        else pass_cnt++;
        reset_n = 1'b1;
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_heartbeat();
        test_square();
        test_pause();
        test_mode_change();
        test_hex();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
